tj_key_leak_tx: RTL and testbench

TJ_KEY_LEAK_TX -- requirements
Module: tj_key_leak_tx

---
 rtl/tj_pkg.sv | 15 +
 rtl/tj_bit_timer.sv | 33 +++
 rtl/tj_key_leak_tx.sv | 134 +++++++++++++
 tb/tb_tj_key_leak_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tj_pkg.sv
// Shared types and frame geometry for the key leakage transmitter.
package tj_pkg;

  localparam int PREAMBLE_W = 8;
  localparam int KEY_W      = 128;
  localparam int FRAME_BITS = PREAMBLE_W + KEY_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_GAP
  } tj_state_e;

endpackage

// File: rtl/tj_bit_timer.sv
// Per-bit cycle counter with end-of-bit (wrap) and mid-bit (half) strobes.
module tj_bit_timer
  import tj_pkg::*;
#(
  parameter int BIT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap,
  output logic half
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] MID  = CW'(BIT_PERIOD / 2 - 1);

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == LAST);
  assign half = en && (cnt == MID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tj_key_leak_tx.sv
// Serial key leakage transmitter: preamble + 128-bit key frames, repeated while armed.
// Build option: TJ_LEAK_MANCHESTER_EN selects Manchester instead of NRZ line coding.
module tj_key_leak_tx
  import tj_pkg::*;
#(
  parameter int                    BIT_PERIOD = 16,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 8'hA5,
  parameter int                    GAP_BITS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tj_trig,
  input  logic [KEY_W-1:0] key,
  output logic             leak_out,
  output logic             busy,
  output logic             frame_done
);

`ifdef TJ_LEAK_MANCHESTER_EN
  localparam bit MANCH = 1'b1;
`else
  localparam bit MANCH = 1'b0;
`endif

  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_W - 1);
  localparam logic [7:0] KEY_LAST  = 8'(KEY_W - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_BITS - 1);

  tj_state_e        state, state_n;
  logic [7:0]       bit_cnt, bit_n, bm1;
  logic [KEY_W-1:0] shreg, sh_n;
  logic             leak_q, leak_n;
  logic             wrap, half, en;

  assign en         = (state != ST_IDLE);
  assign busy       = en;
  assign leak_out   = leak_q;
  assign frame_done = (state == ST_DATA) && (bit_cnt == 8'd0) && wrap;
  assign bm1        = bit_cnt - 8'd1;

  tj_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .wrap(wrap),
    .half(half)
  );

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    leak_n  = leak_q;
    unique case (state)
      ST_IDLE: begin
        leak_n = 1'b0;
        if (tj_trig) begin
          state_n = ST_PRE;
          bit_n   = PRE_LAST;
          sh_n    = key;
          leak_n  = PREAMBLE[PREAMBLE_W-1];
        end
      end
      ST_PRE: begin
        if (wrap) begin
          if (bit_cnt == 8'd0) begin
            state_n = ST_DATA;
            bit_n   = KEY_LAST;
            leak_n  = shreg[KEY_W-1];
          end else begin
            bit_n  = bm1;
            leak_n = |(PREAMBLE & (8'd1 << bm1));
          end
        end else if (MANCH && half) begin
          leak_n = ~leak_q;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          if (bit_cnt == 8'd0) begin
            state_n = ST_GAP;
            bit_n   = GAP_LAST;
            leak_n  = 1'b0;
          end else begin
            bit_n  = bm1;
            sh_n   = {shreg[KEY_W-2:0], 1'b0};
            leak_n = shreg[KEY_W-2];
          end
        end else if (MANCH && half) begin
          leak_n = ~leak_q;
        end
      end
      ST_GAP: begin
        leak_n = 1'b0;
        if (wrap) begin
          if (bit_cnt != 8'd0) begin
            bit_n = bm1;
          end else if (tj_trig) begin
            // re-arm straight into the next frame with a fresh key snapshot
            state_n = ST_PRE;
            bit_n   = PRE_LAST;
            sh_n    = key;
            leak_n  = PREAMBLE[PREAMBLE_W-1];
          end else begin
            state_n = ST_IDLE;
            bit_n   = 8'd0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        bit_n   = 8'd0;
        leak_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 8'd0;
      shreg   <= '0;
      leak_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      leak_q  <= leak_n;
    end
  end

endmodule

// File: tb/tb_tj_key_leak_tx.sv
// Self-checking bench for tj_key_leak_tx: frame-level model plus literal pins.
module tb_tj_key_leak_tx;

  localparam int BP  = 4;
  localparam int GB  = 4;
  localparam int NC  = 2100;
  localparam logic [7:0]   PRE = 8'hA5;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tj_trig = 1'b0;
  logic [127:0] key = K1;
  logic         leak_out, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic tr_leak [NC];
  logic tr_busy [NC];
  logic tr_done [NC];

  tj_key_leak_tx #(
    .BIT_PERIOD(BP),
    .PREAMBLE  (PRE),
    .GAP_BITS  (GB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tj_trig   (tj_trig),
    .key       (key),
    .leak_out  (leak_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic lvl(input logic b, input int c);
`ifdef TJ_LEAK_MANCHESTER_EN
    return (c < BP / 2) ? b : ~b;
`else
    return (c >= 0) ? b : 1'b0;
`endif
  endfunction

  // Model: expected {busy, frame_done, leak_out} per cycle, queued a whole
  // frame plus its gap at a time.
  logic [2:0] q[$];
  logic [2:0] exp_cur = 3'b000;

  task automatic push_frame(input logic [127:0] k);
    logic [135:0] fr;
    fr = {PRE, k};
    for (int i = 135; i >= 0; i--) begin
      for (int c = 0; c < BP; c++) begin
        q.push_back({1'b1, (i == 0 && c == BP - 1), lvl(fr[i], c)});
      end
    end
    for (int g = 0; g < GB * BP; g++) q.push_back(3'b100);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_cur <= 3'b000;
    end else begin
      if (q.size() == 0 && tj_trig) push_frame(key);
      if (q.size() > 0) exp_cur <= q.pop_front();
      else exp_cur <= 3'b000;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({busy, frame_done, leak_out} !== exp_cur) begin
      errors++;
      $display("FAIL model cyc=%0d got={busy,done,leak}=%b want=%b",
               cyc, {busy, frame_done, leak_out}, exp_cur);
    end
    if (cyc < NC) begin
      tr_leak[cyc] = leak_out;
      tr_busy[cyc] = busy;
      tr_done[cyc] = frame_done;
    end
  end

  task automatic chk(input string nm, input int at, input logic act,
                     input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, at, act, want);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int ndone;
    logic [7:0] tail;
    go(3);
    rst = 1'b0;
    go(9);
    tj_trig = 1'b1;
    go(242);
    key = K2;
    go(600);
    tj_trig = 1'b0;
    go(1199);
    tj_trig = 1'b1;
    go(1313);
    rst = 1'b1;
    tj_trig = 1'b0;
    #2;
    chk("async_rst_leak", cyc, leak_out, 1'b0);
    chk("async_rst_busy", cyc, busy, 1'b0);
    chk("async_rst_done", cyc, frame_done, 1'b0);
    go(1315);
    rst = 1'b0;
    go(1399);
    tj_trig = 1'b1;
    go(1420);
    tj_trig = 1'b0;
    go(1990);

    chk("reset_idle_busy", 2, tr_busy[2], 1'b0);
    chk("pre_trig_idle", 9, tr_busy[9], 1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < BP; c++)
        chk("preamble", 10 + 4 * i + c, tr_leak[10 + 4 * i + c],
            lvl(PRE[7 - i], c));
    for (int j = 0; j < 8; j++)
      for (int c = 0; c < BP; c++)
        chk("data_head", 42 + 4 * j + c, tr_leak[42 + 4 * j + c],
            lvl(1'b0, c));
    tail = 8'h0f;
    for (int j = 0; j < 8; j++)
      for (int c = 0; c < BP; c++)
        chk("data_tail", 522 + 4 * j + c, tr_leak[522 + 4 * j + c],
            lvl(tail[7 - j], c));
    ndone = 0;
    for (int t = 10; t < 570; t++) ndone += int'(tr_done[t]);
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL done_count got=%0d want=1", ndone);
    end
    chk("done_at_544th", 553, tr_done[553], 1'b1);
    for (int t = 554; t < 570; t++) begin
      chk("gap_leak", t, tr_leak[t], 1'b0);
      chk("gap_busy", t, tr_busy[t], 1'b1);
    end
    chk("frame2_start", 570, tr_leak[570], 1'b1);
    for (int t = 602; t < 1114; t += 7)
      chk("frame2_ones", t, tr_leak[t], lvl(1'b1, (t - 602) % BP));
    chk("frame2_done", 1113, tr_done[1113], 1'b1);
    chk("idle_after_gap", 1130, tr_busy[1130], 1'b0);
    for (int t = 1316; t < 1400; t += 6)
      chk("no_tx_after_rst", t, tr_busy[t], 1'b0);
    chk("retrig_start", 1400, tr_leak[1400], 1'b1);
    chk("retrig_done", 1943, tr_done[1943], 1'b1);
    chk("retrig_idle", 1960, tr_busy[1960], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
